uart_rx: RTL
============

Name: uart_rx

Overview:
UART receiver, the companion to uart_tx on the serial link. It oversamples the asynchronous serial input at 16x the baud rate, using the shared s_tick baud-rate enable, and reassembles LSB-first data words. Each completed frame is presented on rx_dout with a one-clock rx_done_tick pulse and a framing-error flag. It sits between the pad-side rx line and the core-side consumer, which is typically a FIFO or the APB slave register file.

Parameters:
DBIT, 8, number of data bits per frame.
SB_TICK, 16, s_tick count for the stop bit (16 = 1 stop bit, 24 = 1.5, 32 = 2).

Ports:
clk  input  1  system clock; all logic on posedge.
reset_n  input  1  asynchronous, active-high reset (asserted = 1 clears all state immediately).
s_tick  input  1  baud enable, one clk wide, 16 pulses per bit period; may be tied high.
rx  input  1  asynchronous serial input, idle high.
rx_dout  output  DBIT  last received data word, LSB = first bit on the line.
rx_done_tick  output  1  one-clk pulse when a frame completes.
frame_err  output  1  stop bit sampled low on the last completed frame.

Behaviour:
- Input sync: rx passes through a 2-flop synchronizer (rx_s); the reset value of both flops is 1. The FSM sees rx_s only, so there are 2 clk of latency.
- Registers: state, s (4-bit tick counter, wide enough for SB_TICK-1), n (bit counter, clog2(DBIT) bits), b (DBIT shift register).
- Reset: state=IDLE, s=0, n=0, b=0, rx_dout=0, rx_done_tick=0, frame_err=0.
- All counter and FSM advances are qualified by s_tick, except the IDLE start detection.
- IDLE: when rx_s==0, go to START and set s=0. This check does not need s_tick.
- START: on each s_tick, if s==7 (mid start bit):
  - rx_s==0: go to DATA, s=0, n=0.
  - rx_s==1: false start (glitch); return to IDLE with no done pulse.
  - Otherwise s++.
- DATA: on each s_tick, if s==15 (mid bit): s=0, b={rx_s, b[DBIT-1:1]}; if n==DBIT-1 go to STOP, else n++. Otherwise s++.
- STOP: on each s_tick, if s==SB_TICK-1:
  - rx_dout<=b, frame_err<=~rx_s, rx_done_tick=1 for exactly this clk.
  - Go to IDLE.
  - Otherwise s++.
- rx_done_tick is asserted even on a framing error; rx_dout is still updated.
- rx_dout and frame_err hold their values until the next completed frame.
- Back-to-back frames: from IDLE, a start bit whose first low sample arrives in the clk immediately after the done pulse is accepted. No dead time beyond that single IDLE clk.
- rx held low continuously (break): the frame completes with frame_err=1. The FSM then re-enters START, because rx_s is still 0, and repeats until rx returns high.
- s_tick low: the FSM freezes in START, DATA and STOP; no state is lost.
- Reset asserted mid-frame: return to IDLE immediately with all outputs cleared. A partial frame never produces rx_done_tick.
- rx_done_tick never asserts for two consecutive clks.

Test Plan:
- s_tick tied high, with 0x25 (bits 1,0,1,0,0,1,0,0) serialized at 16 clk/bit, start low and stop high -> exactly one rx_done_tick, about 154 clk after the start edge; rx_dout=0x25, frame_err=0.
- Loopback: uart_tx.tx drives uart_rx.rx with shared clk and s_tick, tx_din=0xA5, then 0x3C back-to-back -> two done pulses, rx_dout=0xA5 then 0x3C, frame_err=0 each time.
- Stop bit forced low for 0x81 -> rx_done_tick=1, rx_dout=0x81, frame_err=1.
- 4-clk low glitch on idle rx (s_tick high) -> returns to IDLE, no rx_done_tick, rx_dout unchanged.
- reset_n pulsed high during data bit 4 of a frame, then a clean 0x5A frame -> no done pulse for the aborted frame; the next frame gives rx_dout=0x5A.
- s_tick as a 1-in-4 enable (64 clk/bit), with 0xFF sent -> rx_dout=0xFF, frame_err=0; done asserts for only 1 clk.

Source files
------------

// File: rtl/uart_rx.sv
// 16x-oversampling UART receiver: LSB-first frames out on rx_dout with a one-clk rx_done_tick and frame_err.
// Latency: 2 clk input sync, done 1 clk after the stop-bit sample; no backpressure, consumer must take rx_dout on rx_done_tick.
module uart_rx #(
    parameter int DBIT    = 8,
    parameter int SB_TICK = 16
) (
    input  logic            clk,
    input  logic            reset_n,
    input  logic            s_tick,
    input  logic            rx,
    output logic [DBIT-1:0] rx_dout,
    output logic            rx_done_tick,
    output logic            frame_err
);

    localparam int SW = (SB_TICK > 16) ? $clog2(SB_TICK) : 4;
    localparam int NW = (DBIT > 1) ? $clog2(DBIT) : 1;

    typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

    state_t          state, state_nx;
    logic [SW-1:0]   s, s_nx;
    logic [NW-1:0]   n, n_nx;
    logic [DBIT-1:0] b, b_nx;
    logic [DBIT-1:0] dout_nx;
    logic            done_nx, ferr_nx;
    logic            rx_m, rx_s;

    // Reset to the idle line level so reset never looks like a start bit.
    always_ff @(posedge clk or posedge reset_n) begin
        if (reset_n) begin
            rx_m <= 1'b1;
            rx_s <= 1'b1;
        end else begin
            rx_m <= rx;
            rx_s <= rx_m;
        end
    end

    always_ff @(posedge clk or posedge reset_n) begin
        if (reset_n) begin
            state        <= IDLE;
            s            <= '0;
            n            <= '0;
            b            <= '0;
            rx_dout      <= '0;
            rx_done_tick <= 1'b0;
            frame_err    <= 1'b0;
        end else begin
            state        <= state_nx;
            s            <= s_nx;
            n            <= n_nx;
            b            <= b_nx;
            rx_dout      <= dout_nx;
            rx_done_tick <= done_nx;
            frame_err    <= ferr_nx;
        end
    end

    always_comb begin
        state_nx = state;
        s_nx     = s;
        n_nx     = n;
        b_nx     = b;
        dout_nx  = rx_dout;
        ferr_nx  = frame_err;
        done_nx  = 1'b0;
        unique case (state)
            IDLE: begin
                if (!rx_s) begin
                    state_nx = START;
                    s_nx     = '0;
                end
            end
            START: begin
                if (s_tick) begin
                    if (s == SW'(7)) begin
                        if (!rx_s) begin
                            state_nx = DATA;
                            s_nx     = '0;
                            n_nx     = '0;
                        end else begin
                            state_nx = IDLE;
                        end
                    end else begin
                        s_nx = s + SW'(1);
                    end
                end
            end
            DATA: begin
                if (s_tick) begin
                    if (s == SW'(15)) begin
                        s_nx = '0;
                        b_nx = {rx_s, b[DBIT-1:1]};
                        if (n == NW'(DBIT - 1)) begin
                            state_nx = STOP;
                        end else begin
                            n_nx = n + NW'(1);
                        end
                    end else begin
                        s_nx = s + SW'(1);
                    end
                end
            end
            STOP: begin
                if (s_tick) begin
                    if (s == SW'(SB_TICK - 1)) begin
                        dout_nx  = b;
                        ferr_nx  = ~rx_s;
                        done_nx  = 1'b1;
                        state_nx = IDLE;
                    end else begin
                        s_nx = s + SW'(1);
                    end
                end
            end
            default: state_nx = IDLE;
        endcase
    end

endmodule
